// File: rtl/status_update_unit.sv
// Write side of the instruction-cache status array: maintains use/valid bits on hits and
// refills, and picks the replacement victim on misses.
module status_update_unit #(
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_BLOCKS  = 4,
    parameter int BLOCK_WIDTH = 2,
    localparam int WAY_WIDTH  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
    localparam int ROW_WIDTH  = NUM_BLOCKS * BLOCK_WIDTH
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic                  i_sa_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ROW_WIDTH-1:0]  i_row,
    input  logic                  i_hit,
    input  logic [WAY_WIDTH-1:0]  i_hit_way,
    input  logic                  i_valid,
    input  logic                  i_fill_done,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [ROW_WIDTH-1:0]  o_w_data,
    output logic [NUM_BLOCKS-1:0] o_w_wmask,
    output logic                  o_w_valid,
    output logic [WAY_WIDTH-1:0]  o_victim_way,
    output logic                  o_victim_valid,
    output logic [1:0]            o_dbg_state
);

    localparam logic [1:0] ST_INIT      = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_WAIT_FILL = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [ROW_WIDTH-1:0]  st_row;
    logic [WAY_WIDTH-1:0]  st_way;

    logic                  accept;
    logic                  fill_fire;
    logic                  fwd_hit;
    logic [ROW_WIDTH-1:0]  eff_row;
    logic [WAY_WIDTH-1:0]  victim;
    logic                  victim_found;
    logic [ROW_WIDTH-1:0]  upd_row;
    logic [WAY_WIDTH-1:0]  upd_way;
    logic                  all_use;
    logic [ROW_WIDTH-1:0]  w_data;
    logic [NUM_BLOCKS-1:0] w_mask;

    // Handshake: a lookup transfers on any cycle where i_valid && o_ready && !i_halt;
    // o_ready depends only on state and i_sa_ready, never on i_valid.
    assign o_ready     = (state == ST_IDLE) && i_sa_ready;
    assign accept      = i_valid && o_ready && !i_halt;
    assign fill_fire   = (state == ST_WAIT_FILL) && i_fill_done && !i_halt;
    assign fwd_hit     = o_w_valid && (o_w_addr == i_addr);
    assign o_dbg_state = state;

    // The array read cannot yet see the write on the output registers, so merge it in.
    always_comb begin
        eff_row = i_row;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (fwd_hit && o_w_wmask[i]) begin
                eff_row[i*BLOCK_WIDTH +: BLOCK_WIDTH] = o_w_data[i*BLOCK_WIDTH +: BLOCK_WIDTH];
            end
        end
    end

    // Victim priority: first invalid way, then first unused way, else way 0.
    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (!victim_found && !eff_row[i*BLOCK_WIDTH+1]) begin
                victim       = WAY_WIDTH'(i);
                victim_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (!victim_found && !eff_row[i*BLOCK_WIDTH]) begin
                victim       = WAY_WIDTH'(i);
                victim_found = 1'b1;
            end
        end
    end

    // Shared write builder for hits and refills; a saturated use vector restarts at the touched way.
    always_comb begin
        upd_way = fill_fire ? st_way : i_hit_way;
        upd_row = fill_fire ? st_row : eff_row;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (WAY_WIDTH'(i) == upd_way) begin
                upd_row[i*BLOCK_WIDTH] = 1'b1;
                if (fill_fire) begin
                    upd_row[i*BLOCK_WIDTH+1] = 1'b1;
                end
            end
        end
        all_use = 1'b1;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            all_use = all_use & upd_row[i*BLOCK_WIDTH];
        end
        w_data = '0;
        w_mask = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (all_use) begin
                w_data[i*BLOCK_WIDTH+1] = upd_row[i*BLOCK_WIDTH+1];
                w_data[i*BLOCK_WIDTH]   = (WAY_WIDTH'(i) == upd_way);
                w_mask[i]               = 1'b1;
            end else if (WAY_WIDTH'(i) == upd_way) begin
                w_data[i*BLOCK_WIDTH+1] = 1'b1;
                w_data[i*BLOCK_WIDTH]   = 1'b1;
                w_mask[i]               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state          <= ST_INIT;
            st_addr        <= '0;
            st_row         <= '0;
            st_way         <= '0;
            o_w_addr       <= '0;
            o_w_data       <= '0;
            o_w_wmask      <= '0;
            o_w_valid      <= 1'b0;
            o_victim_way   <= '0;
            o_victim_valid <= 1'b0;
        end else if (!i_halt) begin
            o_w_valid      <= 1'b0;
            o_victim_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (i_sa_ready) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (accept && i_hit) begin
                        o_w_addr  <= i_addr;
                        o_w_data  <= w_data;
                        o_w_wmask <= w_mask;
                        o_w_valid <= 1'b1;
                    end else if (accept) begin
                        o_victim_way   <= victim;
                        o_victim_valid <= 1'b1;
                        st_addr        <= i_addr;
                        st_row         <= eff_row;
                        st_way         <= victim;
                        state          <= ST_WAIT_FILL;
                    end
                end
                ST_WAIT_FILL: begin
                    if (fill_fire) begin
                        o_w_addr  <= st_addr;
                        o_w_data  <= w_data;
                        o_w_wmask <= w_mask;
                        o_w_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_status_update_unit.sv
// Bench for status_update_unit: cycle model feeds an expected queue checked on the negedge.
module tb_status_update_unit;

    localparam int AW = 4;
    localparam int NB = 4;
    localparam int WW = 2;
    localparam int RW = 8;
    localparam int EW = 17;   // {is_write, addr, data, mask} or {0..., victim_way}

    localparam logic [1:0] M_INIT = 2'd0;
    localparam logic [1:0] M_IDLE = 2'd1;
    localparam logic [1:0] M_WAIT = 2'd2;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          i_halt = 1'b0;
    logic          i_sa_ready = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [RW-1:0] i_row = '0;
    logic          i_hit = 1'b0;
    logic [WW-1:0] i_hit_way = '0;
    logic          i_valid = 1'b0;
    logic          i_fill_done = 1'b0;
    logic          o_ready;
    logic [AW-1:0] o_w_addr;
    logic [RW-1:0] o_w_data;
    logic [NB-1:0] o_w_wmask;
    logic          o_w_valid;
    logic [WW-1:0] o_victim_way;
    logic          o_victim_valid;
    logic [1:0]    o_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic exp_ready = 1'b0;
    logic edge_halt = 1'b0;

    logic [1:0]    m_state;
    logic          m_lw_v;
    logic [AW-1:0] m_lw_a;
    logic [RW-1:0] m_lw_d;
    logic [NB-1:0] m_lw_m;
    logic [AW-1:0] m_st_a;
    logic [RW-1:0] m_st_row;
    logic [WW-1:0] m_st_way;

    // clock / reset
    always #5 clk = ~clk;

    status_update_unit dut (
        .clk(clk), .arst_n(arst_n), .i_halt(i_halt), .i_sa_ready(i_sa_ready),
        .i_addr(i_addr), .i_row(i_row), .i_hit(i_hit), .i_hit_way(i_hit_way),
        .i_valid(i_valid), .i_fill_done(i_fill_done), .o_ready(o_ready),
        .o_w_addr(o_w_addr), .o_w_data(o_w_data), .o_w_wmask(o_w_wmask),
        .o_w_valid(o_w_valid), .o_victim_way(o_victim_way),
        .o_victim_valid(o_victim_valid), .o_dbg_state(o_dbg_state)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] exp_write(input logic [AW-1:0] a, input logic [RW-1:0] row,
                                                input int w, input bit fill);
        logic [NB-1:0] u;
        logic [NB-1:0] v;
        logic [RW-1:0] d;
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            u[i] = row[2*i];
            v[i] = row[2*i+1];
        end
        u[w] = 1'b1;
        if (fill) v[w] = 1'b1;
        d = '0;
        m = '0;
        if (&u) begin
            for (int i = 0; i < NB; i++) begin
                d[2*i+1] = v[i];
                d[2*i]   = (i == w);
            end
            m = '1;
        end else begin
            d[2*w +: 2] = 2'b11;
            m[w] = 1'b1;
        end
        return {1'b1, a, d, m};
    endfunction

    function automatic logic [WW-1:0] exp_victim(input logic [RW-1:0] row);
        for (int i = 0; i < NB; i++) if (!row[2*i+1]) return WW'(i);
        for (int i = 0; i < NB; i++) if (!row[2*i]) return WW'(i);
        return '0;
    endfunction

    // driver: apply one cycle of inputs, step the model, queue what the next edge must produce
    task automatic drive(input logic halt, input logic valid, input logic hit, input logic [WW-1:0] way,
                         input logic [AW-1:0] addr, input logic [RW-1:0] row, input logic fill);
        logic [EW-1:0] e;
        logic          push;
        logic [RW-1:0] eff;
        i_halt = halt; i_valid = valid; i_hit = hit; i_hit_way = way;
        i_addr = addr; i_row = row; i_fill_done = fill;
        exp_ready = (m_state == M_IDLE) && i_sa_ready;
        push = 1'b0;
        e = '0;
        if (!halt) begin
            case (m_state)
                M_INIT: if (i_sa_ready) m_state = M_IDLE;
                M_IDLE: begin
                    if (valid && exp_ready) begin
                        eff = row;
                        if (m_lw_v && m_lw_a == addr)
                            for (int i = 0; i < NB; i++)
                                if (m_lw_m[i]) eff[2*i +: 2] = m_lw_d[2*i +: 2];
                        push = 1'b1;
                        if (hit) begin
                            e = exp_write(addr, eff, int'(way), 1'b0);
                        end else begin
                            e = {15'b0, exp_victim(eff)};
                            m_st_a = addr;
                            m_st_row = eff;
                            m_st_way = exp_victim(eff);
                            m_state = M_WAIT;
                        end
                    end
                end
                M_WAIT: begin
                    if (fill) begin
                        e = exp_write(m_st_a, m_st_row, int'(m_st_way), 1'b1);
                        push = 1'b1;
                        m_state = M_IDLE;
                    end
                end
                default: m_state = M_INIT;
            endcase
            m_lw_v = push && e[EW-1];
            if (m_lw_v) {m_lw_a, m_lw_d, m_lw_m} = e[EW-2:0];
        end
        @(posedge clk);
        #1;
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        i_halt = 1'b0; i_valid = 1'b0; i_fill_done = 1'b0;
        m_state = M_INIT; m_lw_v = 1'b0; m_lw_a = '0; m_lw_d = '0; m_lw_m = '0;
        m_st_a = '0; m_st_row = '0; m_st_way = '0;
        exp_q.delete();
        exp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_w_valid", 32'(o_w_valid), 0);
        check_val("rst_v_valid", 32'(o_victim_valid), 0);
        check_val("rst_w_addr", 32'(o_w_addr), 0);
        check_val("rst_w_data", 32'(o_w_data), 0);
        check_val("rst_w_mask", 32'(o_w_wmask), 0);
        check_val("rst_v_way", 32'(o_victim_way), 0);
        check_val("rst_ready", 32'(o_ready), 0);
        check_val("rst_state", 32'(o_dbg_state), 0);
    endtask

    task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [RW-1:0] d,
                               input logic [NB-1:0] m);
        check_val({tag, "_valid"}, 32'(o_w_valid), 1);
        check_val({tag, "_addr"}, 32'(o_w_addr), 32'(a));
        check_val({tag, "_data"}, 32'(o_w_data), 32'(d));
        check_val({tag, "_mask"}, 32'(o_w_wmask), 32'(m));
    endtask

    // scoreboard: outputs produced by a non-halted edge must match the queue head
    always @(posedge clk) edge_halt <= i_halt;

    always @(negedge clk) begin
        if (arst_n) begin
            check_val("o_ready", 32'(o_ready), 32'(exp_ready));
            if (!edge_halt) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    if (mon_e[EW-1]) begin
                        check_val("sb_w_valid", 32'(o_w_valid), 1);
                        check_val("sb_v_quiet", 32'(o_victim_valid), 0);
                        check_val("sb_w_txn", 32'({o_w_addr, o_w_data, o_w_wmask}), 32'(mon_e[EW-2:0]));
                    end else begin
                        check_val("sb_v_valid", 32'(o_victim_valid), 1);
                        check_val("sb_w_quiet", 32'(o_w_valid), 0);
                        check_val("sb_v_way", 32'(o_victim_way), 32'(mon_e[WW-1:0]));
                    end
                end else begin
                    check_val("sb_no_w", 32'(o_w_valid), 0);
                    check_val("sb_no_v", 32'(o_victim_valid), 0);
                end
            end
        end
    end

    initial begin
        do_reset();
        check_reset_outputs();

        i_sa_ready = 1'b0;
        idle(5);
        check_val("init_hold_state", 32'(o_dbg_state), 0);
        i_sa_ready = 1'b1;
        idle(1);
        check_val("ready_up", 32'(o_ready), 1);

        drive(1'b0, 1'b1, 1'b1, 2'd2, 4'd3, 8'b11_01_00_11, 1'b0);
        check_write("hit_w2", 4'd3, 8'h30, 4'b0100);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 4'd7, 8'b11_10_11_11, 1'b0);
        check_write("hit_sat", 4'd7, 8'hBA, 4'b1111);
        idle(1);

        // miss whose refill saturates the use bits
        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd9, 8'b11_00_11_11, 1'b0);
        check_val("miss1_v_valid", 32'(o_victim_valid), 1);
        check_val("miss1_v_way", 32'(o_victim_way), 2);
        check_val("miss1_ready", 32'(o_ready), 0);
        idle(3);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b1);
        check_write("fill1", 4'd9, 8'hBA, 4'b1111);
        check_val("fill1_ready", 32'(o_ready), 1);

        // miss whose refill leaves other use bits clear
        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd4, 8'b01_00_11_10, 1'b0);
        check_val("miss2_v_way", 32'(o_victim_way), 2);
        idle(3);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b1);
        check_write("fill2", 4'd4, 8'h30, 4'b0100);

        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd8, 8'b11_10_11_11, 1'b0);
        check_val("miss_allv_way", 32'(o_victim_way), 2);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd10, 8'hFF, 1'b0);
        check_val("miss_full_way", 32'(o_victim_way), 0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b1);
        check_write("fill_full", 4'd10, 8'hAB, 4'b1111);
        idle(1);

        // forwarding of back-to-back writes to one row
        drive(1'b0, 1'b1, 1'b1, 2'd0, 4'd5, 8'h00, 1'b0);
        check_write("fwd_a", 4'd5, 8'h03, 4'b0001);
        drive(1'b0, 1'b1, 1'b1, 2'd1, 4'd5, 8'h00, 1'b0);
        check_write("fwd_b", 4'd5, 8'h0C, 4'b0010);
        drive(1'b0, 1'b1, 1'b1, 2'd1, 4'd6, 8'hFA, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 4'd6, 8'hFA, 1'b0);
        check_write("fwd_sat", 4'd6, 8'hAB, 4'b1111);

        // halt freezes outputs; forwarding resumes after release
        drive(1'b0, 1'b1, 1'b1, 2'd1, 4'd6, 8'hFA, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 4'd6, 8'hFA, 1'b0);
        check_write("halt1", 4'd6, 8'h0C, 4'b0010);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 4'd6, 8'hFA, 1'b0);
        check_write("halt2", 4'd6, 8'h0C, 4'b0010);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 4'd6, 8'hFA, 1'b0);
        check_write("halt_rel", 4'd6, 8'hAB, 4'b1111);

        // reset with a miss pending drops it
        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd2, 8'h00, 1'b0);
        idle(1);
        do_reset();
        check_reset_outputs();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 1'b1);
        check_val("post_rst_no_w", 32'(o_w_valid), 0);
        idle(1);

        for (int n = 0; n < 600; n++) begin
            i_sa_ready = ($urandom_range(0, 15) != 0);
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1),
                  WW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), RW'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) < 3));
        end
        i_sa_ready = 1'b1;
        idle(3);
        check_val("queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
